pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Registered program-counter unit for the FYsMIPScpu fetch stage, the parametrised successor to the combinational `pcAdd`. It holds the current PC, computes the next PC for sequential, branch, jump and jump-register flow, and advances under a valid/ready handshake with instruction fetch. It also keeps a small return-address stack (RAS) that records `jal` links and checks `jr` targets against it.

## Interface
Parameters:
- WIDTH, 32, PC/data width; legal values are 32 or 64.
- RESET_PC, 0, PC value loaded by reset; must be word aligned.
- RAS_DEPTH, 4, number of RAS entries; power of two, at least 2.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, synchronous, active-high.
- pc_ready  in  1  fetch accepts the current PC this cycle.
- redirect  in  1  apply the PCSrc selection this cycle.
- PCSrc  in  2  00 sequential, 01 branch, 10 jump, 11 jump-register.
- immediate  in  WIDTH  sign-extended branch offset, in words.
- addr  in  26  jump target field.
- rs  in  WIDTH  jump-register target.
- link  in  1  with redirect: push PC+4 to the RAS (`jal`/`jalr`).
- ret  in  1  with redirect and PCSrc=11: pop the RAS and compare the popped value with rs.
- curPC  out  WIDTH  registered current PC.
- pc_valid  out  1  curPC is presentable to fetch.
- nextPC  out  WIDTH  combinational next-PC target for the current inputs.
- ras_top  out  WIDTH  RAS top entry; 0 when the RAS is empty.
- ras_empty  out  1  RAS holds no entries.
- ras_hit  out  1  registered; the last `ret` pop matched rs.

## Operation
- Target computation:
  - pcplus4 = curPC + 4, modulo 2^WIDTH.
  - 00: pcplus4.
  - 01: pcplus4 + (immediate << 2), truncated to WIDTH.
  - 10: {pcplus4[WIDTH-1:28], addr, 2'b00}.
  - 11: {rs[WIDTH-1:2], 2'b00}; the low bits are forced to zero.
- PC update priority:
  1. RST.
  2. redirect: curPC <= nextPC regardless of pc_ready. PCSrc=00 with redirect behaves as a sequential step.
  3. pc_valid && pc_ready: curPC <= pcplus4.
  4. Otherwise curPC holds.
- pc_valid:
  - 0 in the reset cycle.
  - 1 from the first cycle after RST deasserts, and stays 1.
  - A redirect does not drop pc_valid.
- RAS: circular buffer with pointer `sp` and count `cnt` (0..RAS_DEPTH).
  - Push (redirect && link): write pcplus4 at sp+1 and increment sp. When the RAS is full the oldest entry is overwritten and cnt saturates.
  - Pop (redirect && ret && PCSrc==11): if cnt > 0, decrement sp and cnt, and set ras_hit <= (top == {rs[WIDTH-1:2],2'b00}). If the RAS is empty, nothing is popped and ras_hit <= 0.
  - Push and pop in the same cycle: the top entry is replaced by pcplus4; sp and cnt are unchanged; ras_hit is evaluated against the old top.
  - ret without PCSrc==11 is ignored. link without redirect is ignored.
  - ras_hit updates only on a pop attempt and otherwise holds.
- Reset values: curPC = RESET_PC, pc_valid = 0, cnt = 0, sp = 0, ras_empty = 1, ras_top = 0, ras_hit = 0. A reset in mid-operation discards all RAS contents and any redirect presented in the same cycle.

## Timing
- Redirect latency: the new curPC is visible one cycle after the redirect cycle.
- nextPC is combinational from curPC and the inputs; no latency.
- Stall: while pc_ready = 0 and redirect = 0, curPC holds indefinitely.
- RAS update and ras_hit appear one cycle after the triggering cycle. ras_top and ras_empty reflect registered state.
- Wrap-around: at curPC = 2^WIDTH - 4, a sequential step yields 0.

## Structure
- Shared package `cpu_pkg`:
  - PCSrc encodings: PC_SEQ, PC_BRANCH, PC_JUMP, PC_JR.
  - Constant PC_STEP = 4.
- Sub-module `ras_stack` (params WIDTH, RAS_DEPTH):
  - Inputs: push, pop, push_data.
  - Outputs: top, empty, count.
  - Owns the circular pointer and saturation logic.
- `pc_sequencer` owns target selection, the PC register, pc_valid and ras_hit.

## Test plan
- Reset with RESET_PC=0x00400000, RST=1 for 2 cycles, then pc_ready=1 for 3 cycles -> curPC sequence 0x00400000, 0x00400004, 0x00400008. pc_valid is 0 during reset and 1 after.
- At curPC=0x100, redirect with PCSrc=01 and immediate=0xFFFFFFFE -> curPC=0x0FC. Repeat with pc_ready=0 and no redirect for 3 cycles -> curPC holds.
- At curPC=0x10000010, redirect with PCSrc=10 and addr=0x0000040 -> curPC=0x10000100. At the same PC, redirect with PCSrc=11 and rs=0x00001237 -> curPC=0x00001234.
- Issue 5 `jal` redirects with RAS_DEPTH=4 from PCs 0x0,0x100,0x200,0x300,0x400 -> cnt saturates at 4 and ras_top=0x404. Issue 4 `ret` pops with matching rs -> ras_hit=1 each time. A 5th pop -> ras_empty=1 and ras_hit=0.
- Simultaneous link+ret at curPC=0x500 with top=0x104 and rs=0x104 -> ras_top becomes 0x504, cnt is unchanged, ras_hit=1.
- RST asserted in the same cycle as a redirect with 2 RAS entries held -> next cycle curPC=RESET_PC, ras_empty=1, pc_valid=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared fetch-stage definitions: PCSrc encodings and the sequential PC increment.
package cpu_pkg;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_JR     = 2'b11;

  localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: push-over-full drops the oldest link,
// and a simultaneous push/pop replaces the top in place.
module ras_stack
  import cpu_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           push_data,
  output logic [WIDTH-1:0]           top,
  output logic                       empty,
  output logic [$clog2(RAS_DEPTH):0] count
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam logic [PW:0] DEPTH_CNT = (PW+1)'(RAS_DEPTH);

  logic [WIDTH-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]    sp;
  logic [PW-1:0]    sp_inc;
  logic [PW:0]      cnt;
  logic             has_top;
  logic             replace;

  assign has_top = (cnt != '0);
  assign replace = push && pop && has_top;
  assign sp_inc  = sp + 1'b1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sp  <= '0;
      cnt <= '0;
    end else if (replace) begin
      sp  <= sp;
      cnt <= cnt;
    end else if (push) begin
      sp <= sp_inc;
      if (cnt != DEPTH_CNT) cnt <= cnt + 1'b1;
    end else if (pop && has_top) begin
      sp  <= sp - 1'b1;
      cnt <= cnt - 1'b1;
    end
  end

  // Entries need no reset: anything above cnt is never exposed on top.
  always_ff @(posedge CLK) begin
    if (!RST && push) begin
      if (replace) mem[sp] <= push_data;
      else         mem[sp_inc] <= push_data;
    end
  end

  assign top   = has_top ? mem[sp] : '0;
  assign empty = !has_top;
  assign count = cnt;

endmodule

// File: rtl/pc_sequencer.sv
// Registered fetch-stage program counter with branch/jump/jr targets and a
// return-address stack that checks jr targets against recorded jal links.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  parameter int               RAS_DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             pc_ready,
  input  logic             redirect,
  input  logic [1:0]       PCSrc,
  input  logic [WIDTH-1:0] immediate,
  input  logic [25:0]      addr,
  input  logic [WIDTH-1:0] rs,
  input  logic             link,
  input  logic             ret,
  output logic [WIDTH-1:0] curPC,
  output logic             pc_valid,
  output logic [WIDTH-1:0] nextPC,
  output logic [WIDTH-1:0] ras_top,
  output logic             ras_empty,
  output logic             ras_hit
);

  logic [WIDTH-1:0]           pcplus4;
  logic [WIDTH-1:0]           jr_target;
  logic [$clog2(RAS_DEPTH):0] ras_count;
  logic                       push_req;
  logic                       pop_req;

  assign pcplus4   = curPC + WIDTH'(PC_STEP);
  assign jr_target = rs & ~WIDTH'(3);

  always_comb begin
    nextPC = pcplus4;
    case (PCSrc)
      PC_SEQ:    nextPC = pcplus4;
      PC_BRANCH: nextPC = pcplus4 + (immediate << 2);
      PC_JUMP:   nextPC = {pcplus4[WIDTH-1:28], addr, 2'b00};
      PC_JR:     nextPC = jr_target;
      default:   nextPC = pcplus4;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      curPC    <= RESET_PC;
      pc_valid <= 1'b0;
    end else begin
      pc_valid <= 1'b1;
      if (redirect)                curPC <= nextPC;
      else if (pc_valid && pc_ready) curPC <= pcplus4;
    end
  end

  assign push_req = redirect && link;
  assign pop_req  = redirect && ret && (PCSrc == PC_JR);

  ras_stack #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .CLK       (CLK),
    .RST       (RST),
    .push      (push_req),
    .pop       (pop_req),
    .push_data (pcplus4),
    .top       (ras_top),
    .empty     (ras_empty),
    .count     (ras_count)
  );

  // An empty pop still counts as an attempt and clears the hit flag.
  always_ff @(posedge CLK) begin
    if (RST)          ras_hit <= 1'b0;
    else if (pop_req) ras_hit <= (ras_count != '0) && (ras_top == jr_target);
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized
// traffic against a queue-based reference model of the PC and RAS.
module tb_pc_sequencer;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        CLK = 1'b0;
  logic        rst = 1'b1;
  logic        pc_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [1:0]  pcsrc = 2'b00;
  logic [31:0] immediate = '0;
  logic [25:0] addr = '0;
  logic [31:0] rs = '0;
  logic        link = 1'b0;
  logic        ret = 1'b0;
  logic [31:0] curPC, nextPC, ras_top;
  logic        pc_valid, ras_empty, ras_hit;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_pc;
  logic        m_valid;
  logic        m_hit;
  logic [31:0] ras_q[$];

  always #5 CLK = ~CLK;

  pc_sequencer #(.WIDTH(32), .RESET_PC(RST_PC), .RAS_DEPTH(4)) dut (
    .CLK(CLK), .RST(rst), .pc_ready(pc_ready), .redirect(redirect), .PCSrc(pcsrc),
    .immediate(immediate), .addr(addr), .rs(rs), .link(link), .ret(ret),
    .curPC(curPC), .pc_valid(pc_valid), .nextPC(nextPC), .ras_top(ras_top),
    .ras_empty(ras_empty), .ras_hit(ras_hit)
  );

  function automatic logic [31:0] model_target(input logic [31:0] pc, input logic [1:0] src,
                                               input logic [31:0] imm, input logic [25:0] a,
                                               input logic [31:0] r);
    logic [31:0] p4;
    p4 = pc + 32'd4;
    case (src)
      2'd1:    return p4 + imm * 32'd4;
      2'd2:    return (p4 & 32'hF000_0000) | ({6'd0, a} * 32'd4);
      2'd3:    return r & 32'hFFFF_FFFC;
      default: return p4;
    endcase
  endfunction

  function automatic logic [31:0] model_top();
    return (ras_q.size() > 0) ? ras_q[ras_q.size()-1] : 32'd0;
  endfunction

  task automatic set_in(input logic r, input logic red, input logic rdy, input logic [1:0] src,
                        input logic [31:0] imm, input logic [25:0] a, input logic [31:0] rv,
                        input logic lk, input logic rt);
    rst = r; redirect = red; pc_ready = rdy; pcsrc = src;
    immediate = imm; addr = a; rs = rv; link = lk; ret = rt;
  endtask

  // Advance one clock and update the reference model from the applied inputs.
  task automatic tick();
    logic [31:0] p4, tgt;
    logic push, pop;
    p4  = m_pc + 32'd4;
    tgt = model_target(m_pc, pcsrc, immediate, addr, rs);
    @(posedge CLK);
    if (rst) begin
      m_pc = RST_PC; m_valid = 1'b0; m_hit = 1'b0; ras_q.delete();
    end else begin
      push = redirect && link;
      pop  = redirect && ret && (pcsrc == 2'd3);
      if (pop) m_hit = (ras_q.size() > 0) && (model_top() == (rs & 32'hFFFF_FFFC));
      if (push && pop && ras_q.size() > 0) ras_q[ras_q.size()-1] = p4;
      else if (push) begin
        if (ras_q.size() == 4) void'(ras_q.pop_front());
        ras_q.push_back(p4);
      end else if (pop && ras_q.size() > 0) void'(ras_q.pop_back());
      if (redirect) m_pc = tgt;
      else if (m_valid && pc_ready) m_pc = p4;
      m_valid = 1'b1;
    end
    #1;
  endtask

  task automatic jr_to(input logic [31:0] target);
    set_in(0, 1, 0, 2'd3, 0, 0, target, 0, 0);
    tick();
  endtask

  task automatic test_reset();
    set_in(1, 0, 0, 2'd0, 0, 0, 0, 0, 0);
    tick();
    tick();
    if (curPC !== RST_PC) begin errors++; $display("FAIL reset_pc: got %h want %h", curPC, RST_PC); end
    checks++;
    if (pc_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", pc_valid); end
    checks++;
    if (ras_empty !== 1'b1 || ras_top !== 32'd0 || ras_hit !== 1'b0) begin
      errors++; $display("FAIL reset_ras: empty=%b top=%h hit=%b want 1/0/0", ras_empty, ras_top, ras_hit);
    end
    checks++;
  endtask

  task automatic test_sequential();
    logic [31:0] want [3];
    want[0] = 32'h0040_0000; want[1] = 32'h0040_0004; want[2] = 32'h0040_0008;
    set_in(0, 0, 1, 2'd0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (curPC !== want[i]) begin errors++; $display("FAIL seq_pc[%0d]: got %h want %h", i, curPC, want[i]); end
      checks++;
      if (pc_valid !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d]: got %b want 1", i, pc_valid); end
      checks++;
    end
  endtask

  task automatic test_branch_stall();
    jr_to(32'h100);
    set_in(0, 1, 0, 2'd1, 32'hFFFF_FFFE, 0, 0, 0, 0);
    #1;
    if (nextPC !== 32'h0FC) begin errors++; $display("FAIL branch_next: got %h want 000000fc", nextPC); end
    checks++;
    tick();
    if (curPC !== 32'h0FC) begin errors++; $display("FAIL branch_pc: got %h want 000000fc", curPC); end
    checks++;
    set_in(0, 0, 0, 2'd0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (curPC !== 32'h0FC) begin errors++; $display("FAIL stall_pc[%0d]: got %h want 000000fc", i, curPC); end
      checks++;
    end
  endtask

  task automatic test_wrap();
    jr_to(32'hFFFF_FFFC);
    set_in(0, 0, 1, 2'd0, 0, 0, 0, 0, 0);
    tick();
    if (curPC !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h want 00000000", curPC); end
    checks++;
  endtask

  task automatic test_jump();
    jr_to(32'h1000_0010);
    set_in(0, 1, 0, 2'd2, 0, 26'h40, 0, 0, 0);
    tick();
    if (curPC !== 32'h1000_0100) begin errors++; $display("FAIL jump_pc: got %h want 10000100", curPC); end
    checks++;
    jr_to(32'h1000_0010);
    set_in(0, 1, 0, 2'd3, 0, 0, 32'h0000_1237, 0, 0);
    tick();
    if (curPC !== 32'h0000_1234) begin errors++; $display("FAIL jr_pc: got %h want 00001234", curPC); end
    checks++;
  endtask

  task automatic test_ras();
    logic [31:0] r;
    jr_to(32'h0);
    for (int i = 0; i < 5; i++) begin
      set_in(0, 1, 0, 2'd2, 0, (i < 4) ? 26'((i + 1) * 32'h40) : 26'd0, 0, 1, 0);
      tick();
    end
    if (ras_top !== 32'h404) begin errors++; $display("FAIL ras_sat_top: got %h want 00000404", ras_top); end
    checks++;
    for (int j = 0; j < 4; j++) begin
      r = 32'h404 - 32'(j) * 32'h100;
      set_in(0, 1, 0, 2'd3, 0, 0, r, 0, 1);
      tick();
      if (ras_hit !== 1'b1) begin errors++; $display("FAIL ras_pop_hit[%0d]: got %b want 1", j, ras_hit); end
      checks++;
      if (curPC !== r) begin errors++; $display("FAIL ras_pop_pc[%0d]: got %h want %h", j, curPC, r); end
      checks++;
    end
    if (ras_empty !== 1'b1) begin errors++; $display("FAIL ras_drain_empty: got %b want 1", ras_empty); end
    checks++;
    set_in(0, 1, 0, 2'd3, 0, 0, 32'h4, 0, 1);
    tick();
    if (ras_hit !== 1'b0 || ras_empty !== 1'b1) begin
      errors++; $display("FAIL ras_underflow: hit=%b empty=%b want 0/1", ras_hit, ras_empty);
    end
    checks++;
  endtask

  task automatic test_push_pop();
    jr_to(32'h100);
    set_in(0, 1, 0, 2'd2, 0, 26'h140, 0, 1, 0);
    tick();
    if (curPC !== 32'h500 || ras_top !== 32'h104) begin
      errors++; $display("FAIL pp_setup: pc=%h top=%h want 00000500/00000104", curPC, ras_top);
    end
    checks++;
    set_in(0, 1, 0, 2'd3, 0, 0, 32'h104, 1, 1);
    tick();
    if (ras_top !== 32'h504 || ras_hit !== 1'b1) begin
      errors++; $display("FAIL pp_replace: top=%h hit=%b want 00000504/1", ras_top, ras_hit);
    end
    checks++;
    set_in(0, 1, 0, 2'd3, 0, 0, 32'h504, 0, 1);
    tick();
    if (ras_hit !== 1'b1 || ras_empty !== 1'b1) begin
      errors++; $display("FAIL pp_count: hit=%b empty=%b want 1/1", ras_hit, ras_empty);
    end
    checks++;
  endtask

  task automatic test_reset_mid();
    jr_to(32'h104);
    set_in(0, 1, 0, 2'd2, 0, 26'h80, 0, 1, 0);
    tick();
    set_in(0, 1, 0, 2'd2, 0, 26'h40, 0, 1, 0);
    tick();
    if (ras_empty !== 1'b0 || ras_top !== 32'h204) begin
      errors++; $display("FAIL rm_setup: empty=%b top=%h want 0/00000204", ras_empty, ras_top);
    end
    checks++;
    set_in(1, 1, 1, 2'd3, 0, 0, 32'h800, 1, 1);
    tick();
    if (curPC !== RST_PC || pc_valid !== 1'b0) begin
      errors++; $display("FAIL rm_pc: pc=%h valid=%b want %h/0", curPC, pc_valid, RST_PC);
    end
    checks++;
    if (ras_empty !== 1'b1 || ras_top !== 32'd0 || ras_hit !== 1'b0) begin
      errors++; $display("FAIL rm_ras: empty=%b top=%h hit=%b want 1/0/0", ras_empty, ras_top, ras_hit);
    end
    checks++;
    set_in(0, 0, 0, 2'd0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_random();
    logic [31:0] r, want_next;
    for (int i = 0; i < 400; i++) begin
      r = $urandom();
      if ($urandom_range(0, 1) == 0) r = model_top() | 32'($urandom_range(0, 3));
      set_in($urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
             2'($urandom_range(0, 3)), $urandom(), 26'($urandom()), r,
             $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
      #1;
      want_next = model_target(m_pc, pcsrc, immediate, addr, rs);
      if (nextPC !== want_next) begin errors++; $display("FAIL rnd_next[%0d]: got %h want %h", i, nextPC, want_next); end
      checks++;
      tick();
      if (curPC !== m_pc || pc_valid !== m_valid) begin
        errors++; $display("FAIL rnd_pc[%0d]: pc=%h valid=%b want %h/%b", i, curPC, pc_valid, m_pc, m_valid);
      end
      checks++;
      if (ras_top !== model_top() || ras_empty !== (ras_q.size() == 0) || ras_hit !== m_hit) begin
        errors++; $display("FAIL rnd_ras[%0d]: top=%h empty=%b hit=%b want %h/%b/%b", i, ras_top, ras_empty,
                           ras_hit, model_top(), ras_q.size() == 0, m_hit);
      end
      checks++;
    end
  endtask

  initial begin
    m_pc = RST_PC; m_valid = 1'b0; m_hit = 1'b0;
    test_reset();
    test_sequential();
    test_branch_stall();
    test_wrap();
    test_jump();
    test_ras();
    test_push_pop();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
